// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: data width, FSM state encoding, byte type.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and status strobes out.
// The master modport is the receiver side; slave is the line driver / byte consumer.
interface uart_receiver_if;
  import uart_pkg::*;

  logic       uart_rx;
  uart_byte_t data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  modport master (input uart_rx, output data, output valid, output frame_error, output busy);
  modport slave  (output uart_rx, input data, input valid, input frame_error, input busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit start validation, LSB-first data capture, registered outputs.
// Define UART_RX_SYNC_EN to pass uart_rx through a 2-flop synchronizer first.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 8
) (
  input logic      clk,
  input logic      reset,
  uart_receiver_if.master rx_if
);

  localparam int unsigned HALF  = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;
  logic line_ok;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_fill;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_if.uart_rx),
    .q     (rx_s)
  );

  // The synchronizer's reset value is not a real line observation; ignore it
  // until it has been flushed, so a line held low through reset stays parked.
  always_ff @(posedge clk) begin
    if (reset) sync_fill <= '0;
    else       sync_fill <= {sync_fill[0], 1'b1};
  end

  assign line_ok = sync_fill[1];
`else
  assign rx_s    = rx_if.uart_rx;
  assign line_ok = 1'b1;
`endif

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  uart_byte_t       shreg;
  uart_byte_t       data_q;
  logic             valid_q;
  logic             fe_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_HIGH;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      case (state)
        WAIT_HIGH: begin
          if (rx_s && line_ok) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            if (rx_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              state   <= IDLE;
            end else begin
              fe_q  <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

  assign rx_if.data        = data_q;
  assign rx_if.valid       = valid_q;
  assign rx_if.frame_error = fe_q;
  assign rx_if.busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit by bit, pulses timed against the start edge.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
  localparam int SHIFT = 2;
`else
  localparam int SHIFT = 0;
`endif
  localparam int CPB = 8;
  localparam int LAT = 76 + SHIFT;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  int   valid_cnt, fe_cnt, overlap_cnt, busy_cnt;
  int   last_valid_cyc, last_fe_cyc;
  logic [7:0] last_valid_data;

  int   e0, e0_first, v_first, snap_v, snap_fe, snap_busy;

  uart_receiver_if u_if ();

  uart_receiver #(.CYCLES_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    valid_cnt = 0; fe_cnt = 0; overlap_cnt = 0; busy_cnt = 0;
    last_valid_cyc = -1; last_fe_cyc = -1; last_valid_data = 8'h00;
  end

  always @(negedge clk) begin
    if (u_if.valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc  = cyc;
      last_valid_data = u_if.data;
    end
    if (u_if.frame_error === 1'b1) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (u_if.valid === 1'b1 && u_if.frame_error === 1'b1) overlap_cnt++;
    if (u_if.busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    u_if.uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just before E0+80.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    e0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    u_if.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  u_if.data, 8'h00);
    check("rst_valid", u_if.valid, 1'b0);
    check("rst_fe",    u_if.frame_error, 1'b0);
    check("rst_busy",  u_if.busy, 1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Single good frame
    snap_v = valid_cnt; snap_fe = fe_cnt;
    send_frame(8'h35, 1'b1);
    repeat (4) @(negedge clk);
    check("f35_cnt",  valid_cnt - snap_v, 1);
    check("f35_time", last_valid_cyc, e0 + LAT);
    check("f35_data", u_if.data, 8'h35);
    check("f35_fe",   fe_cnt - snap_fe, 0);
    check("f35_busy", u_if.busy, 1'b0);

    // Two-cycle glitch
    snap_v = valid_cnt; snap_fe = fe_cnt;
    e0 = cyc + 1;
    u_if.uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    u_if.uart_rx = 1'b1;
    wait_cyc(e0 + SHIFT + 1);
    check("gl_busy_hi", u_if.busy, 1'b1);
    wait_cyc(e0 + SHIFT + 4);
    check("gl_busy_lo", u_if.busy, 1'b0);
    repeat (20) @(negedge clk);
    check("gl_valid", valid_cnt - snap_v, 0);
    check("gl_fe",    fe_cnt - snap_fe, 0);
    check("gl_data",  u_if.data, 8'h35);

    // Frame error, then line held low, then a good frame
    snap_v = valid_cnt; snap_fe = fe_cnt;
    send_frame(8'hA5, 1'b0);
    snap_busy = busy_cnt;
    repeat (20) @(negedge clk);
    check("fe_cnt",       fe_cnt - snap_fe, 1);
    check("fe_time",      last_fe_cyc, e0 + LAT);
    check("fe_valid",     valid_cnt - snap_v, 0);
    check("fe_data",      u_if.data, 8'h35);
    check("fe_low_busy",  busy_cnt - snap_busy, 0);
    u_if.uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("fe_next_cnt",  valid_cnt - snap_v, 1);
    check("fe_next_data", u_if.data, 8'h3C);

    // Back-to-back frames
    snap_v = valid_cnt;
    send_frame(8'h00, 1'b1);
    e0_first = e0;
    v_first = last_valid_cyc;
    check("b2b_d0",   last_valid_data, 8'h00);
    check("b2b_t0",   v_first, e0_first + LAT);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_cnt",  valid_cnt - snap_v, 2);
    check("b2b_gap",  last_valid_cyc - v_first, 80);
    check("b2b_d1",   u_if.data, 8'hFF);

    // Reset during data bit 3
    snap_v = valid_cnt; snap_fe = fe_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    u_if.uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_data",  u_if.data, 8'h00);
    check("mr_valid", u_if.valid, 1'b0);
    check("mr_fe",    u_if.frame_error, 1'b0);
    check("mr_busy",  u_if.busy, 1'b0);
    repeat (3) @(negedge clk);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (10) @(negedge clk);
    check("mr_nopulse_v",  valid_cnt - snap_v, 0);
    check("mr_nopulse_fe", fe_cnt - snap_fe, 0);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("mr_next_cnt",  valid_cnt - snap_v, 1);
    check("mr_next_data", u_if.data, 8'h81);

    // Reset with the line held low afterwards
    snap_v = valid_cnt; snap_fe = fe_cnt;
    u_if.uart_rx = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap_busy = busy_cnt;
    repeat (30) @(negedge clk);
    check("rl_busy",  busy_cnt - snap_busy, 0);
    check("rl_valid", valid_cnt - snap_v, 0);
    check("rl_fe",    fe_cnt - snap_fe, 0);
    u_if.uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("rl_next_cnt",  valid_cnt - snap_v, 1);
    check("rl_next_time", last_valid_cyc, e0 + LAT);
    check("rl_next_data", u_if.data, 8'h5A);

    check("no_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
